// File: rtl/pclk_rate_ctrl.sv
// PCLK-domain rate controller: sequences power-up and DataBusWidth changes, then pulses PhyStatus.
// Optional macro PCLK_RATE_ERR_EN adds the sticky Width_Err flag for illegal width requests.
module pclk_rate_ctrl #(
   parameter int POWERUP_CYCLES = 16,
   parameter int SETTLE_CYCLES  = 8,
   parameter int CNT_W          = 8,
   parameter int DEFAULT_WIDTH  = 8
) (
   input  logic       PCLK,
   input  logic       Rst,
   input  logic [5:0] Width_Req,
   input  logic       Width_Req_Valid,
   output logic [5:0] DataBusWidth,
   output logic       PhyStatus,
   output logic       Phy_Ready,
`ifdef PCLK_RATE_ERR_EN
   output logic       Busy,
   output logic       Width_Err
`else
   output logic       Busy
`endif
);

   localparam logic [1:0] ST_POWERUP = 2'd0;
   localparam logic [1:0] ST_STATUS  = 2'd1;
   localparam logic [1:0] ST_IDLE    = 2'd2;
   localparam logic [1:0] ST_SETTLE  = 2'd3;

   localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [5:0]       RESET_WIDTH  = 6'(DEFAULT_WIDTH);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             req_legal;
   logic             req_same;

   assign req_legal = (Width_Req == 6'd8) || (Width_Req == 6'd16) || (Width_Req == 6'd32);
   assign req_same  = (Width_Req == DataBusWidth);

   // Counters compare against param-1 before incrementing, so the Nth edge fires the pulse.
   always_ff @(posedge PCLK or posedge Rst) begin
      if (Rst) begin
         state        <= ST_POWERUP;
         cnt          <= '0;
         DataBusWidth <= RESET_WIDTH;
         PhyStatus    <= 1'b0;
         Phy_Ready    <= 1'b0;
         Busy         <= 1'b1;
`ifdef PCLK_RATE_ERR_EN
         Width_Err    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_POWERUP: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == POWERUP_LAST) begin
                  state     <= ST_STATUS;
                  PhyStatus <= 1'b1;
               end
            end
            ST_STATUS: begin
               state     <= ST_IDLE;
               PhyStatus <= 1'b0;
               Phy_Ready <= 1'b1;
               Busy      <= 1'b0;
            end
            ST_IDLE: begin
               if (Width_Req_Valid) begin
                  if (req_legal && !req_same) begin
                     state        <= ST_SETTLE;
                     DataBusWidth <= Width_Req;
                     Phy_Ready    <= 1'b0;
                     Busy         <= 1'b1;
                     cnt          <= '0;
                  end else if (req_legal) begin
                     state     <= ST_STATUS;
                     PhyStatus <= 1'b1;
                     Busy      <= 1'b1;
                  end
`ifdef PCLK_RATE_ERR_EN
                  else begin
                     Width_Err <= 1'b1;
                  end
`endif
               end
            end
            ST_SETTLE: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == SETTLE_LAST) begin
                  state     <= ST_STATUS;
                  PhyStatus <= 1'b1;
               end
            end
            default: begin
               state <= ST_POWERUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pclk_rate_ctrl.sv
// Self-checking bench for pclk_rate_ctrl: directed vector table, corner sequences and a
// randomized run against a timestamp-based reference model.
module tb_pclk_rate_ctrl;

   localparam int POWERUP = 16;
   localparam int SETTLE  = 8;

   logic       PCLK = 1'b0;
   logic       Rst  = 1'b1;
   logic [5:0] Width_Req = 6'd0;
   logic       Width_Req_Valid = 1'b0;
   logic [5:0] DataBusWidth;
   logic       PhyStatus;
   logic       Phy_Ready;
   logic       Busy;
`ifdef PCLK_RATE_ERR_EN
   logic       Width_Err;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: tracks the edge number of the next PhyStatus pulse instead of states.
   int         m_edge;
   int         m_pulse;
   logic [5:0] m_width;
   logic       m_ps, m_ready, m_busy, m_err;

   typedef struct {
      logic       v;
      logic [5:0] req;
      logic [5:0] w;
      logic       ps;
      logic       rdy;
      logic       bsy;
   } vec_t;

   vec_t vecs[14];

   pclk_rate_ctrl #(
      .POWERUP_CYCLES(POWERUP),
      .SETTLE_CYCLES (SETTLE),
      .CNT_W         (8),
      .DEFAULT_WIDTH (8)
   ) dut (
      .PCLK           (PCLK),
      .Rst            (Rst),
      .Width_Req      (Width_Req),
      .Width_Req_Valid(Width_Req_Valid),
      .DataBusWidth   (DataBusWidth),
      .PhyStatus      (PhyStatus),
      .Phy_Ready      (Phy_Ready),
`ifdef PCLK_RATE_ERR_EN
      .Busy           (Busy),
      .Width_Err      (Width_Err)
`else
      .Busy           (Busy)
`endif
   );

   always #5 PCLK = ~PCLK;

   task automatic cmp(input string tag, input string field, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s.%s actual=%0d required=%0d", tag, field, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [5:0] w, input logic ps,
                              input logic rdy, input logic bsy);
      cmp(tag, "DataBusWidth", int'(DataBusWidth), int'(w));
      cmp(tag, "PhyStatus", int'(PhyStatus), int'(ps));
      cmp(tag, "Phy_Ready", int'(Phy_Ready), int'(rdy));
      cmp(tag, "Busy", int'(Busy), int'(bsy));
   endtask

   task automatic checkModel(input string tag);
      checkOutput(tag, m_width, m_ps, m_ready, m_busy);
`ifdef PCLK_RATE_ERR_EN
      cmp(tag, "Width_Err", int'(Width_Err), int'(m_err));
`endif
   endtask

   task automatic modelReset();
      m_edge  = 0;
      m_pulse = POWERUP;
      m_width = 6'd8;
      m_ps    = 1'b0;
      m_ready = 1'b0;
      m_busy  = 1'b1;
      m_err   = 1'b0;
   endtask

   task automatic modelEdge(input logic v, input logic [5:0] r);
      m_edge++;
      m_ps = (m_edge == m_pulse);
      if (m_edge == m_pulse + 1) begin
         m_ready = 1'b1;
         m_busy  = 1'b0;
      end else if (!m_busy && v) begin
         if (r == 6'd8 || r == 6'd16 || r == 6'd32) begin
            if (r != m_width) begin
               m_width = r;
               m_ready = 1'b0;
               m_busy  = 1'b1;
               m_pulse = m_edge + SETTLE;
            end else begin
               m_ps    = 1'b1;
               m_busy  = 1'b1;
               m_pulse = m_edge;
            end
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   // Inputs change on the falling edge; outputs are checked on the next falling edge.
   task automatic applyStimulus(input logic v, input logic [5:0] r);
      Width_Req_Valid = v;
      Width_Req       = r;
      @(posedge PCLK);
      modelEdge(v, r);
      @(negedge PCLK);
      Width_Req_Valid = 1'b0;
   endtask

   task automatic doReset(input string tag);
      Rst = 1'b1;
      #1;
      modelReset();
      checkOutput(tag, 6'd8, 1'b0, 1'b0, 1'b1);
`ifdef PCLK_RATE_ERR_EN
      cmp(tag, "Width_Err", int'(Width_Err), 0);
`endif
      @(negedge PCLK);
      Rst = 1'b0;
   endtask

   task automatic powerUpCheck(input string tag);
      for (int e = 1; e <= POWERUP + 1; e++) begin
         applyStimulus(1'b0, 6'd0);
         checkModel(tag);
         if (e == POWERUP)
            checkOutput({tag, "_pulse"}, 6'd8, 1'b1, 1'b0, 1'b1);
         if (e == POWERUP + 1)
            checkOutput({tag, "_ready"}, 6'd8, 1'b0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      int pulses;
      logic [5:0] rq;

      // Directed vectors starting from IDLE at width 8.
      vecs[0] = '{1'b1, 6'd32, 6'd32, 1'b0, 1'b0, 1'b1};
      for (int i = 1; i <= 7; i++)
         vecs[i] = '{1'b0, 6'd0, 6'd32, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 6'd0,  6'd32, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 6'd0,  6'd32, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 6'd32, 6'd32, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 6'd0,  6'd32, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 6'd12, 6'd32, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 6'd0,  6'd32, 1'b0, 1'b1, 1'b0};

      @(negedge PCLK);
      doReset("reset");
      powerUpCheck("powerup");

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].v, vecs[i].req);
         checkOutput($sformatf("vec%0d", i), vecs[i].w, vecs[i].ps, vecs[i].rdy, vecs[i].bsy);
         checkModel($sformatf("vec%0d_model", i));
      end
`ifdef PCLK_RATE_ERR_EN
      cmp("illegal", "Width_Err", int'(Width_Err), 1);
`endif

      // Second request during SETTLE is dropped.
      pulses = 0;
      applyStimulus(1'b1, 6'd16);
      checkModel("drop_accept");
      applyStimulus(1'b1, 6'd32);
      checkModel("drop_req");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, 6'd0);
         checkModel("drop_settle");
         if (PhyStatus) pulses++;
      end
      cmp("drop", "pulses", pulses, 1);
      cmp("drop", "DataBusWidth", int'(DataBusWidth), 16);

      // Reset in the middle of SETTLE after a change to 16.
      applyStimulus(1'b1, 6'd8);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 6'd0);
      checkModel("back_to_8");
      applyStimulus(1'b1, 6'd16);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 6'd0);
      checkModel("mid_settle");
      doReset("mid_reset");
      powerUpCheck("repowerup");

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            doReset("rand_reset");
         end else begin
            case ($urandom_range(0, 5))
               0: rq = 6'd8;
               1: rq = 6'd16;
               2: rq = 6'd32;
               3: rq = 6'd12;
               4: rq = 6'd0;
               default: rq = 6'($urandom_range(0, 63));
            endcase
            applyStimulus(($urandom_range(0, 2) == 0), rq);
            checkModel("random");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
